// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain / byte serializer.
//   state_t : FSM state encoding (IDLE, REQ, LOAD, SEND)
//   BYTE_W  : width of one byte on the link side
package fifo_drain_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_drain_tx.sv
// Drains DW-bit words from a synchronous FIFO (registered dout) and
// serializes each word into bytes on a valid/ready byte stream.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   en            : allows new FIFO reads; a word in progress always completes
//   fifo_empty    : FIFO empty flag, sampled only in IDLE
//   fifo_dout     : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : one-cycle read strobe per word
//   tx_data/valid : byte stream towards the link, held stable under backpressure
//   tx_ready      : link accepts a byte when tx_valid && tx_ready
//   busy          : high whenever the FSM is not IDLE
//   words_sent    : count of fully transmitted words, wraps modulo 2^CNT_W
module fifo_drain_tx
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned NBYTES    = DW / 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DW-1:0]     fifo_dout,
    output logic              fifo_rd_en,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t              state_q;
    logic [DW-1:0]       word_q;
    logic [IDX_W-1:0]    idx_q;
    logic                rd_en_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                tx_valid_q;
    logic [CNT_W-1:0]    words_sent_q;

    // Byte idx of a word in transmit order.
    function automatic logic [BYTE_W-1:0] sel_byte(input logic [DW-1:0] w,
                                                   input logic [IDX_W-1:0] idx);
        int unsigned   pos;
        logic [DW-1:0] shifted;
        pos     = MSB_FIRST ? (NBYTES - 1 - 32'(idx)) : 32'(idx);
        shifted = w >> (pos * BYTE_W);
        return shifted[BYTE_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_q       <= '0;
            idx_q        <= '0;
            rd_en_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            words_sent_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // rd_en is registered, so it is raised on entry to REQ
                    // and is high for exactly the REQ cycle.
                    if (en && !fifo_empty) begin
                        state_q <= REQ;
                        rd_en_q <= 1'b1;
                    end
                end
                REQ: begin
                    rd_en_q <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    // First byte is taken straight from fifo_dout so it is
                    // presented in the first SEND cycle.
                    word_q     <= fifo_dout;
                    idx_q      <= '0;
                    tx_data_q  <= sel_byte(fifo_dout, '0);
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx_q == IDX_W'(NBYTES - 1)) begin
                            tx_valid_q   <= 1'b0;
                            tx_data_q    <= '0;
                            words_sent_q <= words_sent_q + CNT_W'(1);
                            state_q      <= IDLE;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            tx_data_q <= sel_byte(word_q, idx_q + IDX_W'(1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != IDLE);
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Testbench for fifo_drain_tx: two instances (MSB-first and LSB-first), each
// fed by a small 8-deep synchronous FIFO with registered read data.
module tb_fifo_drain_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rst;
    logic        en        [2];
    logic        tx_ready  [2];
    logic        fifo_empty[2];
    logic [31:0] fifo_dout [2];
    logic        rd_en     [2];
    logic [7:0]  tx_data   [2];
    logic        tx_valid  [2];
    logic        busy      [2];
    logic [15:0] words_sent[2];
    logic        wr_en     [2];
    logic [31:0] wr_data   [2];

    logic [31:0] mem [2][8];
    logic [2:0]  wp  [2];
    logic [2:0]  rp  [2];
    logic [3:0]  cnt [2];

    int checks = 0;
    int errors = 0;
    int rd_cnt[2];
    int bad_rd[2];
    int hs    [2];
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    // Reference FIFO pair, reset independently of the DUTs.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (fifo_rst) begin
                wp[g]        <= '0;
                rp[g]        <= '0;
                cnt[g]       <= '0;
                fifo_dout[g] <= '0;
            end else begin
                if (wr_en[g] && cnt[g] != 4'd8) begin
                    mem[g][wp[g]] <= wr_data[g];
                    wp[g]         <= wp[g] + 3'd1;
                end
                if (rd_en[g] && cnt[g] != 4'd0) begin
                    fifo_dout[g] <= mem[g][rp[g]];
                    rp[g]        <= rp[g] + 3'd1;
                end
                cnt[g] <= cnt[g] + 4'((wr_en[g] && cnt[g] != 4'd8) ? 1 : 0)
                                 - 4'((rd_en[g] && cnt[g] != 4'd0) ? 1 : 0);
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) fifo_empty[g] = (cnt[g] == 4'd0);
    end

    fifo_drain_tx #(.DW(32), .MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_dout(fifo_dout[0]), .fifo_rd_en(rd_en[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]),
        .words_sent(words_sent[0])
    );

    fifo_drain_tx #(.DW(32), .MSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_dout(fifo_dout[1]), .fifo_rd_en(rd_en[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]),
        .words_sent(words_sent[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte scoreboard and read-strobe bookkeeping for one instance.
    task automatic score_one(input int g);
        int         n;
        logic [7:0] e;
        n = (g == 0) ? qa.size() : qb.size();
        if (tx_valid[g]) begin
            if (n == 0) begin
                check(g == 0 ? "extra_byte_a" : "extra_byte_b", 32'(tx_valid[g]), 32'd0);
            end else begin
                e = (g == 0) ? qa[0] : qb[0];
                check(g == 0 ? "byte_a" : "byte_b", 32'(tx_data[g]), 32'(e));
                if (tx_ready[g]) begin
                    if (g == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                    hs[g]++;
                end
            end
        end
        if (rd_en[g]) begin
            rd_cnt[g]++;
            if (fifo_empty[g]) bad_rd[g]++;
        end
    endtask

    task automatic mid();
        @(negedge clk);
        score_one(0);
        score_one(1);
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            mid();
            go();
        end
    endtask

    // Writes one word into FIFO g (takes one cycle) and queues its bytes
    // in the order that instance should send them.
    task automatic push(input int g, input logic [31:0] w);
        wr_en[g]   = 1'b1;
        wr_data[g] = w;
        if (g == 0) begin
            qa.push_back(w[31:24]); qa.push_back(w[23:16]);
            qa.push_back(w[15:8]);  qa.push_back(w[7:0]);
        end else begin
            qb.push_back(w[7:0]);   qb.push_back(w[15:8]);
            qb.push_back(w[23:16]); qb.push_back(w[31:24]);
        end
        mid();
        go();
        wr_en[g] = 1'b0;
    endtask

    logic [7:0]  t1_rd   = 8'b0000_0010;
    logic [7:0]  t1_v    = 8'b0111_1000;
    logic [7:0]  t1_busy = 8'b0111_1110;
    int          rd0;
    logic [31:0] w;

    initial begin
        rst = 1'b1;
        fifo_rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            en[g] = 1'b0; tx_ready[g] = 1'b0; wr_en[g] = 1'b0; wr_data[g] = '0;
            rd_cnt[g] = 0; bad_rd[g] = 0; hs[g] = 0;
        end
        go(); go(); go();
        mid();
        for (int g = 0; g < 2; g++) begin
            check("rst_rd_en", 32'(rd_en[g]), 32'd0);
            check("rst_tx_valid", 32'(tx_valid[g]), 32'd0);
            check("rst_tx_data", 32'(tx_data[g]), 32'd0);
            check("rst_busy", 32'(busy[g]), 32'd0);
            check("rst_words_sent", 32'(words_sent[g]), 32'd0);
        end
        go();
        rst = 1'b0;
        fifo_rst = 1'b0;
        cyc(2);

        // Single word, cycle-exact latency.
        push(0, 32'hA1B2C3D4);
        en[0] = 1'b1;
        tx_ready[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mid();
            check("t1_rd_en", 32'(rd_en[0]), 32'(t1_rd[c]));
            check("t1_valid", 32'(tx_valid[0]), 32'(t1_v[c]));
            check("t1_busy", 32'(busy[0]), 32'(t1_busy[c]));
            go();
        end
        mid();
        check("t1_words_sent", 32'(words_sent[0]), 32'd1);
        go();
        en[0] = 1'b0;

        // Backpressure with tx_ready pattern 1,0,0 from the first SEND cycle.
        push(0, 32'hA1B2C3D4);
        rd0 = hs[0];
        en[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tx_ready[0] = (c % 3 == 0);
            mid();
            if (c == 5) check("bp_hold_b2", 32'(tx_data[0]), 32'hB2);
            go();
        end
        mid();
        check("bp_handshakes", 32'(hs[0] - rd0), 32'd4);
        check("bp_words_sent", 32'(words_sent[0]), 32'd2);
        check("bp_busy", 32'(busy[0]), 32'd0);
        go();
        en[0] = 1'b0;
        tx_ready[0] = 1'b1;

        // Back-to-back: eight words, then idle with an empty FIFO.
        for (int i = 0; i < 8; i++) begin
            w = {4{8'(i)}};
            push(0, w);
        end
        rd0 = rd_cnt[0];
        en[0] = 1'b1;
        cyc(62);
        mid();
        check("b2b_rd_pulses", 32'(rd_cnt[0] - rd0), 32'd8);
        check("b2b_words_sent", 32'(words_sent[0]), 32'd10);
        check("b2b_bytes_left", 32'(qa.size()), 32'd0);
        check("b2b_busy", 32'(busy[0]), 32'd0);
        check("b2b_rd_on_empty", 32'(bad_rd[0]), 32'd0);
        go();
        en[0] = 1'b0;

        // en dropped during the second byte: word completes, next read blocked.
        push(0, 32'h11223344);
        push(0, 32'hCAFEF00D);
        rd0 = rd_cnt[0];
        en[0] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 4) en[0] = 1'b0;
            mid();
            if (c == 4) check("en_second_byte", 32'(tx_data[0]), 32'h22);
            go();
        end
        mid();
        check("en_rd_pulses", 32'(rd_cnt[0] - rd0), 32'd1);
        check("en_words_sent", 32'(words_sent[0]), 32'd11);
        check("en_busy", 32'(busy[0]), 32'd0);
        check("en_bytes_pending", 32'(qa.size()), 32'd4);
        check("en_fifo_nonempty", 32'(fifo_empty[0]), 32'd0);
        go();
        en[0] = 1'b1;
        cyc(10);
        mid();
        check("en_resume_rd", 32'(rd_cnt[0] - rd0), 32'd2);
        check("en_resume_words", 32'(words_sent[0]), 32'd12);
        check("en_resume_bytes", 32'(qa.size()), 32'd0);
        go();
        en[0] = 1'b0;

        // Reset after the first byte of a word.
        push(0, 32'h55667788);
        push(0, 32'h99AABBCC);
        en[0] = 1'b1;
        tx_ready[0] = 1'b1;
        cyc(4);
        rst = 1'b1;
        tx_ready[0] = 1'b0;
        mid();
        go();
        rst = 1'b0;
        tx_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) void'(qa.pop_front());
        mid();
        check("rstm_tx_valid", 32'(tx_valid[0]), 32'd0);
        check("rstm_busy", 32'(busy[0]), 32'd0);
        check("rstm_words_sent", 32'(words_sent[0]), 32'd0);
        check("rstm_tx_data", 32'(tx_data[0]), 32'd0);
        go();
        cyc(10);
        mid();
        check("rstm_next_words", 32'(words_sent[0]), 32'd1);
        check("rstm_next_bytes", 32'(qa.size()), 32'd0);
        go();
        en[0] = 1'b0;

        // LSB-first instance with counter wrap.
        force dut_b.words_sent_q = 16'hFFFF;
        go();
        release dut_b.words_sent_q;
        mid();
        check("lsb_preset", 32'(words_sent[1]), 32'hFFFF);
        go();
        push(1, 32'hDEADBEEF);
        en[1] = 1'b1;
        tx_ready[1] = 1'b1;
        cyc(10);
        mid();
        check("lsb_wrap", 32'(words_sent[1]), 32'h0000);
        check("lsb_handshakes", 32'(hs[1]), 32'd4);
        check("lsb_bytes_left", 32'(qb.size()), 32'd0);
        check("lsb_busy", 32'(busy[1]), 32'd0);
        check("lsb_rd_on_empty", 32'(bad_rd[1]), 32'd0);
        check("a_rd_on_empty", 32'(bad_rd[0]), 32'd0);
        go();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_drain_tx.md
Name: fifo_drain_tx

Overview:
Drains 32-bit words from the team's 8-deep synchronous FIFO and serializes each word into bytes on an 8-bit valid/ready stream. It drives the FIFO read side (rd_en, empty, registered dout) and is the consumer counterpart to the FIFO write path. Sits between the FIFO and a byte-wide link transmitter (UART/SPI-style framer).

Parameters:
DW, 32, FIFO word width; must be a multiple of 8.
NBYTES, DW/8, bytes per word (derived; do not override).
MSB_FIRST, 1, 1 = most-significant byte sent first, 0 = least-significant first.
CNT_W, 16, width of words_sent counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  enables starting new FIFO reads; does not abort a word in progress
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  DW  FIFO read data, valid the cycle after a rd_en pulse
fifo_rd_en  out  1  FIFO read strobe, one-cycle pulse per word
tx_data  out  8  byte to link
tx_valid  out  1  tx_data valid
tx_ready  in  1  link accepts byte when tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
words_sent  out  CNT_W  count of fully transmitted words

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=IDLE, fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, words_sent=0, shift register=0, byte index=0.
- FSM states: IDLE, REQ, LOAD, SEND.
- IDLE: if en && !fifo_empty, go to REQ; otherwise stay.
- REQ: fifo_rd_en=1 for exactly this cycle (Moore output); go to LOAD unconditionally.
- LOAD: capture fifo_dout into the word register; byte index=0; go to SEND.
- SEND: tx_valid=1; tx_data = byte[index] (MSB_FIRST: index 0 = bits DW-1:DW-8; else bits 7:0).
- SEND handshake: on tx_valid && tx_ready, increment index. On the last byte (index==NBYTES-1), increment words_sent and return to IDLE.
- Backpressure: tx_data and tx_valid hold stable while tx_ready=0; no byte is dropped or duplicated.
- Latency: fifo_empty seen low in IDLE at cycle 0 -> rd_en high in cycle 1 -> first tx_valid in cycle 3. With tx_ready held high, one word every NBYTES+3 cycles.
- en deasserted in REQ/LOAD/SEND: the current word completes; only the next IDLE->REQ transition is blocked.
- fifo_empty is sampled only in IDLE; it is ignored elsewhere.
- Exactly one fifo_rd_en pulse per word; rd_en is never asserted when empty was high at the IDLE decision.
- words_sent wraps modulo 2^CNT_W (0xFFFF -> 0x0000 for CNT_W=16).
- rst mid-word: the word is discarded, and all outputs take reset values on the next edge.
- tx_ready asserted outside SEND is ignored.

Decomposition:
- Shared package fifo_drain_pkg: state encoding constants (IDLE=2'd0, REQ=2'd1, LOAD=2'd2, SEND=2'd3) and BYTE_W=8.
- No sub-module. Byte selection is an inline mux on the index; the FIFO itself is instantiated only in the testbench.

Test Plan:
- Single word: FIFO preloaded with 0xA1B2C3D4, en=1, tx_ready=1 -> one rd_en pulse in cycle 1; bytes A1,B2,C3,D4 in cycles 3-6; words_sent=1; busy falls in cycle 7.
- Backpressure: same word, tx_ready toggling 1,0,0,1,... -> tx_data held at B2 during stalls; exactly 4 handshakes; byte sequence unchanged.
- Back-to-back and empty: 8 words 0x00000000..0x07070707 -> 32 bytes in order, 8 rd_en pulses, words_sent=8; no rd_en while fifo_empty=1.
- en gating: drop en during the second byte of 0x11223344 -> word completes (11,22,33,44); no further rd_en until en=1 again, although the FIFO is non-empty.
- Reset mid-word: rst asserted after byte 0x55 of 0x55667788 -> next cycle tx_valid=0, busy=0, words_sent=0; after release, the next FIFO word transmits cleanly.
- MSB_FIRST=0 plus wrap: word 0xDEADBEEF -> EF,BE,AD,DE; words_sent forced to 0xFFFF before the word -> reads 0x0000 after it.
